// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and segment table for disp_arbiter
//
// Contents:
//   CNT_W          dwell counter width
//   SEG_BLANK      all-segments-off pattern (active-low)
//   SEG_TABLE      16-entry hex digit -> {dp,g,f,e,d,c,b,a} active-low code
//   state_t        arbiter FSM state encoding
//   owner_t        identity of the most recently granted requester
//   lead_zero_mask which of the three upper digits are leading zeros
package disp_pkg;

  localparam int CNT_W = 26;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Element 0 is the rightmost entry; dp (bit 7) is always 1 (off).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW_A = 2'd1,
    ST_SHOW_B = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // Bit 2 -> digit 3, bit 1 -> digit 2, bit 0 -> digit 1. A digit is a
  // leading zero only if it and every digit to its left are zero. Digit 0
  // is never blanked so a value of zero still shows a single "0".
  function automatic logic [2:0] lead_zero_mask(input logic [15:0] value);
    logic [2:0] mask;
    mask[2] = (value[15:12] == 4'h0);
    mask[1] = mask[2] && (value[11:8] == 4'h0);
    mask[0] = mask[1] && (value[7:4] == 4'h0);
    return mask;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low 7-segment decoder
//
// Ports:
//   nibble  in   4  hex digit value
//   seg     out  8  active-low pattern {dp,g,f,e,d,c,b,a}
module hex_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - two-requester round-robin arbiter for a 4-digit display
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst            in   1   synchronous active-high reset
//   req_a, req_b   in   1   display requests, held until granted
//   data_a, data_b in   16  four hex digits, [15:12] leftmost
//   gnt_a, gnt_b   out  1   one-cycle acknowledge, data captured that cycle
//   seg3..seg0     out  8   registered active-low segment patterns
//   busy           out  1   high while a dwell is running
//
// Parameter HOLD_CYCLES: minimum dwell per grant in clk cycles (1..2^26-1).
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits at capture.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  seg3,
  output logic [7:0]  seg2,
  output logic [7:0]  seg1,
  output logic [7:0]  seg0,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  owner_t           last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             arb_point;
  logic             grant_a, grant_b;
  logic [15:0]      cap_data;
  logic [2:0]       blank;
  logic [7:0]       dec3, dec2, dec1, dec0;
  logic [7:0]       seg3_nxt, seg2_nxt, seg1_nxt, seg0_nxt;
  logic             gnt_a_nxt, gnt_b_nxt, busy_nxt;

  // Arbitration decision is kept apart from the next-state block so the
  // decoders sit between two independent combinational processes.
  always_comb begin
    arb_point = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      ST_IDLE:              arb_point = 1'b1;
      ST_SHOW_A, ST_SHOW_B: arb_point = (cnt == '0);
      default:              arb_point = 1'b1;
    endcase
    if (arb_point) begin
      // On a tie the requester not granted last time wins.
      if (req_a && (!req_b || last_grant == OWNER_B)) begin
        grant_a = 1'b1;
      end else if (req_b) begin
        grant_b = 1'b1;
      end
    end
  end

  assign cap_data = grant_b ? data_b : data_a;

  hex_to_seg u_dec3 (.nibble(cap_data[15:12]), .seg(dec3));
  hex_to_seg u_dec2 (.nibble(cap_data[11:8]),  .seg(dec2));
  hex_to_seg u_dec1 (.nibble(cap_data[7:4]),   .seg(dec1));
  hex_to_seg u_dec0 (.nibble(cap_data[3:0]),   .seg(dec0));

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = lead_zero_mask(cap_data);
`else
  assign blank = 3'b000;
`endif

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    gnt_a_nxt      = 1'b0;
    gnt_b_nxt      = 1'b0;
    seg3_nxt       = seg3;
    seg2_nxt       = seg2;
    seg1_nxt       = seg1;
    seg0_nxt       = seg0;

    if (grant_a || grant_b) begin
      state_nxt      = grant_a ? ST_SHOW_A : ST_SHOW_B;
      last_grant_nxt = grant_a ? OWNER_A : OWNER_B;
      cnt_nxt        = CNT_LOAD;
      gnt_a_nxt      = grant_a;
      gnt_b_nxt      = grant_b;
      seg3_nxt       = blank[2] ? SEG_BLANK : dec3;
      seg2_nxt       = blank[1] ? SEG_BLANK : dec2;
      seg1_nxt       = blank[0] ? SEG_BLANK : dec1;
      seg0_nxt       = dec0;
    end else if (arb_point) begin
      // Dwell finished (or already idle) with nobody waiting; segs hold.
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      cnt_nxt = cnt - CNT_W'(1);
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= OWNER_B;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      busy       <= 1'b0;
      seg3       <= SEG_BLANK;
      seg2       <= SEG_BLANK;
      seg1       <= SEG_BLANK;
      seg0       <= SEG_BLANK;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      gnt_a      <= gnt_a_nxt;
      gnt_b      <= gnt_b_nxt;
      busy       <= busy_nxt;
      seg3       <= seg3_nxt;
      seg2       <= seg2_nxt;
      seg1       <= seg1_nxt;
      seg0       <= seg0_nxt;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - scoreboard testbench for disp_arbiter (HOLD_CYCLES 4 and 1)
module tb_disp_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        req_a4, req_b4, gnt_a4, gnt_b4, busy4;
  logic [15:0] data_a4, data_b4;
  logic [7:0]  s3_4, s2_4, s1_4, s0_4;
  logic [31:0] segs4;

  logic        req_a1, req_b1, gnt_a1, gnt_b1, busy1;
  logic [15:0] data_a1, data_b1;
  logic [7:0]  s3_1, s2_1, s1_1, s0_1;
  logic [31:0] segs1;

  assign segs4 = {s3_4, s2_4, s1_4, s0_4};
  assign segs1 = {s3_1, s2_1, s1_1, s0_1};

  disp_arbiter #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_a(req_a4), .data_a(data_a4), .req_b(req_b4), .data_b(data_b4),
    .gnt_a(gnt_a4), .gnt_b(gnt_b4),
    .seg3(s3_4), .seg2(s2_4), .seg1(s1_4), .seg0(s0_4),
    .busy(busy4)
  );

  disp_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a1), .data_a(data_a1), .req_b(req_b1), .data_b(data_b1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1),
    .seg3(s3_1), .seg2(s2_1), .seg1(s1_1), .seg0(s0_1),
    .busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_a;
    logic [31:0] segs;
  } exp_t;

  exp_t sb4[$];
  exp_t sb1[$];

  function automatic logic [7:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: ref_seg = 8'hC0;  4'h1: ref_seg = 8'hF9;
      4'h2: ref_seg = 8'hA4;  4'h3: ref_seg = 8'hB0;
      4'h4: ref_seg = 8'h99;  4'h5: ref_seg = 8'h92;
      4'h6: ref_seg = 8'h82;  4'h7: ref_seg = 8'hF8;
      4'h8: ref_seg = 8'h80;  4'h9: ref_seg = 8'h90;
      4'hA: ref_seg = 8'h88;  4'hB: ref_seg = 8'h83;
      4'hC: ref_seg = 8'hC6;  4'hD: ref_seg = 8'hA1;
      4'hE: ref_seg = 8'h86;  default: ref_seg = 8'h8E;
    endcase
  endfunction

  function automatic logic [31:0] ref_segs(input logic [15:0] v);
    logic [7:0] d3, d2, d1, d0;
    d3 = ref_seg(v[15:12]);
    d2 = ref_seg(v[11:8]);
    d1 = ref_seg(v[7:4]);
    d0 = ref_seg(v[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (v[15:12] == 4'h0) begin
      d3 = 8'hFF;
      if (v[11:8] == 4'h0) begin
        d2 = 8'hFF;
        if (v[7:4] == 4'h0) d1 = 8'hFF;
      end
    end
`endif
    return {d3, d2, d1, d0};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    req_a4 = 1'b0; req_b4 = 1'b0; data_a4 = '0; data_b4 = '0;
    req_a1 = 1'b0; req_b1 = 1'b0; data_a1 = '0; data_b1 = '0;
    repeat (2) @(negedge clk);
    total++; if (segs4 !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_segs4 got=%h want=ffffffff", segs4); end
    total++; if ({gnt_a4, gnt_b4} !== 2'b00) begin bad++; $display("FAIL reset_gnt4 got=%b want=00", {gnt_a4, gnt_b4}); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", busy4); end
    total++; if (segs1 !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_segs1 got=%h want=ffffffff", segs1); end
    total++; if ({gnt_a1, gnt_b1} !== 2'b00) begin bad++; $display("FAIL reset_gnt1 got=%b want=00", {gnt_a1, gnt_b1}); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
    rst = 1'b0;
  endtask

  task automatic test_single_a;
    int   waited;
    exp_t e;
    logic saw_gnt;
    data_a4 = 16'h12AF; req_a4 = 1'b1;
    e.is_a = 1'b1; e.segs = ref_segs(16'h12AF); sb4.push_back(e);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!(gnt_a4 || gnt_b4) && waited < 20);
    req_a4 = 1'b0;
    total++; if (waited != 1) begin bad++; $display("FAIL single_latency got=%0d want=1", waited); end
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      total++; if ({gnt_a4, gnt_b4} !== {e.is_a, ~e.is_a}) begin bad++; $display("FAIL single_gnt got=%b want=%b", {gnt_a4, gnt_b4}, {e.is_a, ~e.is_a}); end
      total++; if (segs4 !== e.segs) begin bad++; $display("FAIL single_segs got=%h want=%h", segs4, e.segs); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL single_busy cyc=%0d got=%b want=1", i, busy4); end
      if (i > 0) begin
        total++; if ({gnt_a4, gnt_b4} !== 2'b00) begin bad++; $display("FAIL single_gnt_pulse cyc=%0d got=%b want=00", i, {gnt_a4, gnt_b4}); end
      end
      // B requests mid-dwell and withdraws before the dwell ends.
      if (i == 0) begin req_b4 = 1'b1; data_b4 = 16'h5555; end
      if (i == 1) req_b4 = 1'b0;
      @(negedge clk);
    end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy4); end
    total++; if (segs4 !== ref_segs(16'h12AF)) begin bad++; $display("FAIL single_hold_segs got=%h want=%h", segs4, ref_segs(16'h12AF)); end
    saw_gnt = 1'b0;
    repeat (4) begin
      if (gnt_a4 || gnt_b4) saw_gnt = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_gnt !== 1'b0) begin bad++; $display("FAIL withdraw_no_gnt got=%b want=0", saw_gnt); end
    total++; if (segs4 !== ref_segs(16'h12AF)) begin bad++; $display("FAIL withdraw_segs got=%h want=%h", segs4, ref_segs(16'h12AF)); end
  endtask

  task automatic test_round_robin;
    int   cyc, last_cyc, n;
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_a4 = 16'h0123; data_b4 = 16'h4567;
    req_a4 = 1'b1; req_b4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.is_a = (k % 2 == 0);
      e.segs = e.is_a ? ref_segs(16'h0123) : ref_segs(16'h4567);
      sb4.push_back(e);
    end
    cyc = 0; last_cyc = 0; n = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt_a4 || gnt_b4) begin
        if (sb4.size() > 0) begin
          e = sb4.pop_front();
          total++; if ({gnt_a4, gnt_b4} !== {e.is_a, ~e.is_a}) begin bad++; $display("FAIL rr_order n=%0d got=%b want=%b", n, {gnt_a4, gnt_b4}, {e.is_a, ~e.is_a}); end
          total++; if (segs4 !== e.segs) begin bad++; $display("FAIL rr_segs n=%0d got=%h want=%h", n, segs4, e.segs); end
        end
        total++;
        if (n == 0 && cyc != 1) begin bad++; $display("FAIL rr_first_latency got=%0d want=1", cyc); end
        else if (n > 0 && cyc - last_cyc != 4) begin bad++; $display("FAIL rr_gap n=%0d got=%0d want=4", n, cyc - last_cyc); end
        last_cyc = cyc;
        n++;
        if (n == 4) begin req_a4 = 1'b0; req_b4 = 1'b0; end
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL rr_timeout got=%0d grants want=4", n); end
  endtask

  task automatic test_reset_mid_dwell;
    int   w;
    exp_t e;
    w = 0;
    while (busy4 && w < 20) begin @(negedge clk); w++; end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL midrst_wait_idle got=%b want=0", busy4); end
    data_a4 = 16'h89AB; req_a4 = 1'b1;
    e.is_a = 1'b1; e.segs = ref_segs(16'h89AB); sb4.push_back(e);
    @(negedge clk);
    req_a4 = 1'b0;
    e = sb4.pop_front();
    total++; if ({gnt_a4, segs4} !== {1'b1, e.segs}) begin bad++; $display("FAIL midrst_grant got=%b/%h want=1/%h", gnt_a4, segs4, e.segs); end
    @(negedge clk);
    total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy4); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy4); end
    total++; if (segs4 !== 32'hFFFFFFFF) begin bad++; $display("FAIL midrst_segs got=%h want=ffffffff", segs4); end
    total++; if ({gnt_a4, gnt_b4} !== 2'b00) begin bad++; $display("FAIL midrst_gnt got=%b want=00", {gnt_a4, gnt_b4}); end
  endtask

  task automatic test_blank;
    logic [15:0] vals [2];
    int          w;
    exp_t        e;
    vals[0] = 16'h0007;
    vals[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (busy4 && w < 20) begin @(negedge clk); w++; end
      data_a4 = vals[k]; req_a4 = 1'b1;
      e.is_a = 1'b1; e.segs = ref_segs(vals[k]); sb4.push_back(e);
      w = 0;
      do begin @(negedge clk); w++; end while (!gnt_a4 && w < 20);
      req_a4 = 1'b0;
      total++; if (gnt_a4 !== 1'b1) begin bad++; $display("FAIL blank_gnt val=%h got=%b want=1", vals[k], gnt_a4); end
      if (sb4.size() > 0) begin
        e = sb4.pop_front();
        total++; if (segs4 !== e.segs) begin bad++; $display("FAIL blank_segs val=%h got=%h want=%h", vals[k], segs4, e.segs); end
      end
    end
    w = 0;
    while (busy4 && w < 20) begin @(negedge clk); w++; end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    exp_t        e;
    d = 16'($urandom);
    data_b1 = d; req_b1 = 1'b1;
    e.is_a = 1'b0; e.segs = ref_segs(d); sb1.push_back(e);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        total++; if ({gnt_a1, gnt_b1} !== 2'b01) begin bad++; $display("FAIL b2b_gnt cyc=%0d got=%b want=01", i, {gnt_a1, gnt_b1}); end
        total++; if (segs1 !== e.segs) begin bad++; $display("FAIL b2b_segs cyc=%0d got=%h want=%h", i, segs1, e.segs); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=1", i, busy1); end
      end
      if (i < 7) begin
        d = 16'($urandom);
        data_b1 = d;
        e.is_a = 1'b0; e.segs = ref_segs(d); sb1.push_back(e);
      end else begin
        req_b1 = 1'b0;
      end
    end
    @(negedge clk);
    total++; if ({gnt_a1, gnt_b1, busy1} !== 3'b000) begin bad++; $display("FAIL b2b_end got=%b want=000", {gnt_a1, gnt_b1, busy1}); end
  endtask

  task automatic test_alternate;
    exp_t e;
    data_a1 = 16'h3C3C; data_b1 = 16'hD00D;
    req_a1 = 1'b1; req_b1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e.is_a = (k % 2 == 0);
      e.segs = e.is_a ? ref_segs(16'h3C3C) : ref_segs(16'hD00D);
      sb1.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        total++; if ({gnt_a1, gnt_b1} !== {e.is_a, ~e.is_a}) begin bad++; $display("FAIL alt_order cyc=%0d got=%b want=%b", i, {gnt_a1, gnt_b1}, {e.is_a, ~e.is_a}); end
        total++; if (segs1 !== e.segs) begin bad++; $display("FAIL alt_segs cyc=%0d got=%h want=%h", i, segs1, e.segs); end
      end
    end
    req_a1 = 1'b0; req_b1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_a;
    test_round_robin;
    test_reset_mid_dwell;
    test_blank;
    test_back_to_back;
    test_alternate;
    total++; if (sb4.size() != 0 || sb1.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", sb4.size(), sb1.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
